// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   - RV32I load/store funct3 encodings used for sizing and extension
//   - responder FSM state type
//   - level of the reset input when reset is asserted
package dmem_pkg;

  localparam logic RST_ACTIVE = 1'b0;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_lane_fmt.sv
// dmem_lane_fmt: combinational byte-lane formatter for RV32I loads/stores.
// Ports:
//   we      in   1 = store, 0 = load
//   funct3  in   RV32I funct3 of the access
//   lane    in   byte offset within the word (little-endian)
//   wdata   in   right-justified store data
//   rword   in   word currently held at the addressed location
//   be      out  byte-enable mask for the write
//   wword   out  store data placed on the addressed lanes
//   rdata   out  sign/zero-extended load data
//   bad     out  misaligned access or illegal funct3
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        bad
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    rbyte = rword[{lane, 3'b000} +: 8];
    rhalf = rword[{lane[1], 4'b0000} +: 16];
    be    = 4'b0000;
    wword = 32'h0;
    rdata = 32'h0;
    bad   = 1'b0;
    // Store data is replicated across lanes so only the enable mask moves.
    case (funct3)
      F3_B, F3_BU: begin
        bad   = we && (funct3 == F3_BU);
        be    = 4'b0001 << lane;
        wword = {4{wdata[7:0]}};
        rdata = (funct3 == F3_B) ? {{24{rbyte[7]}}, rbyte} : {24'h0, rbyte};
      end
      F3_H, F3_HU: begin
        bad   = lane[0] || (we && (funct3 == F3_HU));
        be    = 4'b0011 << lane;
        wword = {2{wdata[15:0]}};
        rdata = (funct3 == F3_H) ? {{16{rhalf[15]}}, rhalf} : {16'h0, rhalf};
      end
      F3_W: begin
        bad   = (lane != 2'b00);
        be    = 4'b1111;
        wword = wdata;
        rdata = rword;
      end
      default: bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder for the RV32I core.
// Accepts a request on req_valid/req_ready, waits WAIT_CYCLES, performs the
// access and returns a one-cycle rsp_valid with load data or an error flag.
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready, req_we, req_addr, req_wdata, req_funct3
//   rsp_valid, rsp_rdata, rsp_err
//   stat_loads/stat_stores/stat_errs (only when DMEM_STATS_EN is defined)
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | wait states after accept
// RESP  | access performed, response registered on this edge
module dmem_responder
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
`ifdef DMEM_STATS_EN
  output logic [31:0] stat_loads,
  output logic [31:0] stat_stores,
  output logic [31:0] stat_errs,
`endif
  output logic        rsp_err
);

  localparam int          AW     = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN   = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WAIT_N = 4'(WAIT_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic          oor;
  logic [3:0]    be;
  logic [31:0]   wword;
  logic [31:0]   fmt_rdata;
  logic          bad;
  logic          access_err;
  logic          wr_go;

  assign off        = addr_q - BASE_ADDR;
  assign idx        = off[AW+1:2];
  assign oor        = (off >= SPAN);
  assign access_err = oor || bad;

  dmem_lane_fmt u_lane_fmt (
    .we     (we_q),
    .funct3 (f3_q),
    .lane   (off[1:0]),
    .wdata  (wdata_q),
    .rword  (mem[idx]),
    .be     (be),
    .wword  (wword),
    .rdata  (fmt_rdata),
    .bad    (bad)
  );

  // Held low while reset is asserted even though the state is already IDLE.
  assign req_ready = (state_q == IDLE) && (reset != RST_ACTIVE);

  // Gating with the live reset level makes reset win over a coincident RESP edge.
  assign wr_go = (state_q == RESP) && we_q && !access_err && (reset != RST_ACTIVE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    f3_d        = f3_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'h0;
    rsp_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          f3_d    = req_funct3;
          cnt_d   = 4'd0;
          state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_d == WAIT_N) begin
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = access_err;
        rsp_rdata_d = (we_q || access_err) ? 32'h0 : fmt_rdata;
        cnt_d       = 4'd0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (reset == RST_ACTIVE) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      f3_q        <= 3'b000;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      f3_q        <= f3_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Storage is intentionally not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_go) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

`ifdef DMEM_STATS_EN
  logic [31:0] stat_loads_q, stat_loads_d;
  logic [31:0] stat_stores_q, stat_stores_d;
  logic [31:0] stat_errs_q, stat_errs_d;

  // Counters move on the same edge that raises rsp_valid, so they are
  // already updated in the response cycle; all saturate at all-ones.
  always_comb begin
    stat_loads_d  = stat_loads_q;
    stat_stores_d = stat_stores_q;
    stat_errs_d   = stat_errs_q;
    if (state_q == RESP) begin
      if (access_err) begin
        if (stat_errs_q != '1) stat_errs_d = stat_errs_q + 32'd1;
      end else if (we_q) begin
        if (stat_stores_q != '1) stat_stores_d = stat_stores_q + 32'd1;
      end else begin
        if (stat_loads_q != '1) stat_loads_d = stat_loads_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (reset == RST_ACTIVE) begin
      stat_loads_q  <= 32'h0;
      stat_stores_q <= 32'h0;
      stat_errs_q   <= 32'h0;
    end else begin
      stat_loads_q  <= stat_loads_d;
      stat_stores_q <= stat_stores_d;
      stat_errs_q   <= stat_errs_d;
    end
  end

  assign stat_loads  = stat_loads_q;
  assign stat_stores = stat_stores_q;
  assign stat_errs   = stat_errs_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int WAIT_CYCLES = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [2:0]  req_funct3 = 3'b000;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
`ifdef DMEM_STATS_EN
  logic [31:0] stat_loads, stat_stores, stat_errs;
`endif

  int checks = 0;
  int failures = 0;
  int exp_loads = 0;
  int exp_stores = 0;
  int exp_errs = 0;

  dmem_responder #(
    .BASE_ADDR   (32'h1000_0000),
    .DEPTH_WORDS (1024),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
`ifdef DMEM_STATS_EN
    .stat_loads (stat_loads),
    .stat_stores(stat_stores),
    .stat_errs  (stat_errs),
`endif
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_stats(input string tag);
`ifdef DMEM_STATS_EN
    check({tag, ":stat_loads"},  stat_loads,  32'(exp_loads));
    check({tag, ":stat_stores"}, stat_stores, 32'(exp_stores));
    check({tag, ":stat_errs"},   stat_errs,   32'(exp_errs));
`else
    check({tag, ":no_rsp"}, 32'(rsp_valid), 32'd0);
`endif
  endtask

  // One request: drive at negedge, scramble inputs after accept, then measure
  // latency and check the response against the hand-computed values.
  task automatic xfer(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err);
    int waited;
    int lat;
    bit got;
    @(negedge clk);
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({tag, ":ready_before"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_wdata  = wdata;
    req_funct3 = f3;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_we     = ~we;
    req_addr   = ~addr;
    req_wdata  = ~wdata;
    req_funct3 = 3'b111;
    check({tag, ":ready_busy"}, 32'(req_ready), 32'd0);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (rsp_valid) got = 1'b1;
    end
    check({tag, ":latency"}, 32'(lat), 32'(WAIT_CYCLES + 1));
    check({tag, ":rdata"}, rsp_rdata, exp_rdata);
    check({tag, ":err"}, 32'(rsp_err), 32'(exp_err));
    check({tag, ":ready_rsp"}, 32'(req_ready), 32'd1);
    if (exp_err) exp_errs++;
    else if (we) exp_stores++;
    else exp_loads++;
`ifdef DMEM_STATS_EN
    check({tag, ":stat_loads"},  stat_loads,  32'(exp_loads));
    check({tag, ":stat_stores"}, stat_stores, 32'(exp_stores));
    check({tag, ":stat_errs"},   stat_errs,   32'(exp_errs));
`endif
    @(posedge clk);
    #1;
    check({tag, ":valid_drop"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #1;
    check("rst:ready", 32'(req_ready), 32'd0);
    check("rst:valid", 32'(rsp_valid), 32'd0);
    check("rst:rdata", rsp_rdata, 32'd0);
    check("rst:err", 32'(rsp_err), 32'd0);
    check_stats("rst");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst:ready_after", 32'(req_ready), 32'd1);

    // Word store/load
    xfer("sw_10",  1'b1, 3'b010, 32'h1000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0);
    xfer("lw_10",  1'b0, 3'b010, 32'h1000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // Byte store, signed/unsigned byte loads
    xfer("sb_11",  1'b1, 3'b000, 32'h1000_0011, 32'h1234_5680, 32'h0, 1'b0);
    xfer("lb_11",  1'b0, 3'b000, 32'h1000_0011, 32'h0, 32'hFFFF_FF80, 1'b0);
    xfer("lbu_11", 1'b0, 3'b100, 32'h1000_0011, 32'h0, 32'h0000_0080, 1'b0);
    xfer("lw_10b", 1'b0, 3'b010, 32'h1000_0010, 32'h0, 32'hDEAD_80EF, 1'b0);

    // Misaligned accesses
    xfer("lh_13",  1'b0, 3'b001, 32'h1000_0013, 32'h0, 32'h0, 1'b1);
    xfer("lw_12",  1'b0, 3'b010, 32'h1000_0012, 32'h0, 32'h0, 1'b1);
    xfer("sh_11",  1'b1, 3'b001, 32'h1000_0011, 32'h0000_5555, 32'h0, 1'b1);
    xfer("lw_10c", 1'b0, 3'b010, 32'h1000_0010, 32'h0, 32'hDEAD_80EF, 1'b0);

    // Halfword store on upper lanes, signed/unsigned half loads
    xfer("sh_16",  1'b1, 3'b001, 32'h1000_0016, 32'h7777_ABCD, 32'h0, 1'b0);
    xfer("lhu_16", 1'b0, 3'b101, 32'h1000_0016, 32'h0, 32'h0000_ABCD, 1'b0);
    xfer("lh_16",  1'b0, 3'b001, 32'h1000_0016, 32'h0, 32'hFFFF_ABCD, 1'b0);
    xfer("lb_17",  1'b0, 3'b000, 32'h1000_0017, 32'h0, 32'hFFFF_FFAB, 1'b0);

    // Range boundaries
    xfer("sw_00",  1'b1, 3'b010, 32'h1000_0000, 32'h1111_1111, 32'h0, 1'b0);
    xfer("sw_ffc", 1'b1, 3'b010, 32'h1000_0FFC, 32'h0BAD_F00D, 32'h0, 1'b0);
    xfer("lw_ffc", 1'b0, 3'b010, 32'h1000_0FFC, 32'h0, 32'h0BAD_F00D, 1'b0);
    xfer("sw_end", 1'b1, 3'b010, 32'h1000_1000, 32'h9999_9999, 32'h0, 1'b1);
    xfer("sb_end", 1'b1, 3'b000, 32'h1000_1000, 32'h0000_0099, 32'h0, 1'b1);
    xfer("lw_low", 1'b0, 3'b010, 32'h0FFF_FFFC, 32'h0, 32'h0, 1'b1);
    xfer("lw_00",  1'b0, 3'b010, 32'h1000_0000, 32'h0, 32'h1111_1111, 1'b0);

    // Illegal funct3
    xfer("ld_f3_3",  1'b0, 3'b011, 32'h1000_0000, 32'h0, 32'h0, 1'b1);
    xfer("ld_f3_6",  1'b0, 3'b110, 32'h1000_0000, 32'h0, 32'h0, 1'b1);
    xfer("st_f3_3",  1'b1, 3'b011, 32'h1000_0000, 32'h7777_7777, 32'h0, 1'b1);
    xfer("st_f3_4",  1'b1, 3'b100, 32'h1000_0000, 32'h0000_0077, 32'h0, 1'b1);
    xfer("lw_00b",   1'b0, 3'b010, 32'h1000_0000, 32'h0, 32'h1111_1111, 1'b0);

    // Reset asserted during WAIT aborts the store
    xfer("sw_20",  1'b1, 3'b010, 32'h1000_0020, 32'hCAFE_F00D, 32'h0, 1'b0);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_addr   = 32'h1000_0020;
    req_wdata  = 32'h1234_5678;
    req_funct3 = 3'b010;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_loads = 0;
    exp_stores = 0;
    exp_errs = 0;
    #1;
    check("abort:ready_in_rst", 32'(req_ready), 32'd0);
    check("abort:valid_in_rst", 32'(rsp_valid), 32'd0);
    check_stats("abort");
    repeat (2) begin
      @(posedge clk);
      #1;
      check("abort:valid_hold", 32'(rsp_valid), 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("abort:valid_after", 32'(rsp_valid), 32'd0);
      check("abort:ready_after", 32'(req_ready), 32'd1);
    end
    xfer("lw_20a", 1'b0, 3'b010, 32'h1000_0020, 32'h0, 32'hCAFE_F00D, 1'b0);

    // Reset asserted while in RESP: no write commits
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_addr   = 32'h1000_0020;
    req_wdata  = 32'h5555_5555;
    req_funct3 = 3'b010;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_loads = 0;
    exp_stores = 0;
    exp_errs = 0;
    @(posedge clk);
    #1;
    check("rstresp:valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    xfer("lw_20b", 1'b0, 3'b010, 32'h1000_0020, 32'h0, 32'hCAFE_F00D, 1'b0);

    // Mix for the statistics counters: 2 loads, 1 store, 1 misaligned load
    xfer("sw_24",  1'b1, 3'b010, 32'h1000_0024, 32'h0102_0304, 32'h0, 1'b0);
    xfer("lbu_26", 1'b0, 3'b100, 32'h1000_0026, 32'h0, 32'h0000_0002, 1'b0);
    xfer("lh_25",  1'b0, 3'b001, 32'h1000_0025, 32'h0, 32'h0, 1'b1);
    check_stats("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
